// File: rtl/atomic_update_scheduler_if.sv
// Handshake bundle between the update requesters and atomic_update_scheduler.
//
// Parameters:
//   N_PROC      number of procedural requesters
//   N_CONT      number of continuous-update requesters
// Signals:
//   proc_req    per-requester request / beat valid
//   proc_last   final beat of a procedural sequence (qualified by req & gnt)
//   proc_gnt    one-hot procedural grant (registered)
//   cont_req    single-beat continuous update requests
//   cont_gnt    one-hot continuous grant (registered)
//   busy        scheduler is not idle
//   owner_cont  current grant belongs to the continuous class
//   owner_id    index of the granted requester, 0 when idle
//   timeout     one-cycle pulse on a forced release of a stalled sequence
// Modports:
//   master      requester side
//   slave       scheduler side
interface atomic_update_scheduler_if #(
  parameter int N_PROC = 4,
  parameter int N_CONT = 2
);
  logic [N_PROC-1:0] proc_req;
  logic [N_PROC-1:0] proc_last;
  logic [N_PROC-1:0] proc_gnt;
  logic [N_CONT-1:0] cont_req;
  logic [N_CONT-1:0] cont_gnt;
  logic              busy;
  logic              owner_cont;
  logic [3:0]        owner_id;
  logic              timeout;

  modport master (
    output proc_req, proc_last, cont_req,
    input  proc_gnt, cont_gnt, busy, owner_cont, owner_id, timeout
  );

  modport slave (
    input  proc_req, proc_last, cont_req,
    output proc_gnt, cont_gnt, busy, owner_cont, owner_id, timeout
  );
endinterface

// File: rtl/atomic_update_scheduler.sv
// Arbitrates one shared state-update port between N_PROC procedural
// requesters (multi-beat, atomic once granted) and N_CONT continuous-update
// requesters (single-beat, batched between procedural sequences).
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    atomic_update_scheduler_if.slave (requests in; grants, busy,
//          owner_cont, owner_id, timeout out -- all registered)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no grant outstanding; arbitrate every cycle (cont first)
// PROC_RUN | one procedural requester owns the port until its last beat
//          | or until the idle watchdog forces a release
// CONT_RUN | serving a batch of continuous requests, one cycle per grant
module atomic_update_scheduler #(
  parameter int N_PROC   = 4,
  parameter int N_CONT   = 2,
  parameter int MAX_IDLE = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  atomic_update_scheduler_if.slave bus
);

  localparam int PW = (N_PROC > 1) ? $clog2(N_PROC) : 1;
  localparam int IW = $clog2(MAX_IDLE);
  localparam logic [IW-1:0] IDLE_LIMIT = IW'(MAX_IDLE - 1);

  typedef enum logic [1:0] {IDLE, PROC_RUN, CONT_RUN} state_t;

  state_t            state;
  logic [PW-1:0]     rr_ptr;
  logic [IW-1:0]     idle_cnt;
  logic [N_CONT-1:0] served;

  logic              proc_beat;
  logic              proc_done;
  logic [PW-1:0]     rr_after_owner;
  logic [PW-1:0]     arb_base;
  logic [N_PROC-1:0] proc_rot;
  logic              proc_found;
  logic [3:0]        proc_idx;
  logic [N_PROC-1:0] proc_pick;
  logic [N_CONT-1:0] cont_pend;
  logic [N_CONT-1:0] cont_pick;
  logic [3:0]        cont_idx;

  // Arbitration outcome, evaluated the same way from every state.
  state_t            arb_state;
  logic [N_PROC-1:0] arb_proc_gnt;
  logic [N_CONT-1:0] arb_cont_gnt;
  logic [3:0]        arb_owner;
  logic              arb_cont;

  always_comb begin
    // Only the owner holds a grant, so masking with proc_gnt isolates its
    // beat and last without indexing by owner.
    proc_beat = |(bus.proc_req & bus.proc_gnt);
    proc_done = |(bus.proc_req & bus.proc_gnt & bus.proc_last);

    rr_after_owner = (int'(bus.owner_id) >= N_PROC - 1) ? '0
                                                         : PW'(int'(bus.owner_id) + 1);
    // On a procedural release the pointer advances in the same edge that
    // re-arbitrates, so search from the post-release value.
    arb_base = (state == PROC_RUN) ? rr_after_owner : rr_ptr;

    // Rotate so bit k corresponds to requester (arb_base + k) mod N_PROC.
    proc_rot   = N_PROC'({bus.proc_req, bus.proc_req} >> arb_base);
    proc_found = 1'b0;
    proc_idx   = '0;
    for (int k = 0; k < N_PROC; k++) begin
      if (!proc_found && proc_rot[k]) begin
        proc_found = 1'b1;
        proc_idx   = 4'((int'(arb_base) + k) % N_PROC);
      end
    end
    proc_pick = N_PROC'(1) << proc_idx;

    // A just-served requester drops its request one cycle late; excluding
    // both the served mask and the live grant keeps it from a double grant.
    // Outside CONT_RUN both masks are zero, so this is plain cont_req.
    cont_pend = bus.cont_req & ~(served | bus.cont_gnt);
    cont_pick = cont_pend & (~cont_pend + N_CONT'(1));
    cont_idx  = '0;
    for (int k = N_CONT - 1; k >= 0; k--) begin
      if (cont_pend[k]) cont_idx = 4'(k);
    end

    arb_state    = IDLE;
    arb_proc_gnt = '0;
    arb_cont_gnt = '0;
    arb_owner    = '0;
    arb_cont     = 1'b0;
    if (|cont_pend) begin
      arb_state    = CONT_RUN;
      arb_cont_gnt = cont_pick;
      arb_owner    = cont_idx;
      arb_cont     = 1'b1;
    end else if (proc_found) begin
      arb_state    = PROC_RUN;
      arb_proc_gnt = proc_pick;
      arb_owner    = proc_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      idle_cnt       <= '0;
      served         <= '0;
      bus.proc_gnt   <= '0;
      bus.cont_gnt   <= '0;
      bus.busy       <= 1'b0;
      bus.owner_cont <= 1'b0;
      bus.owner_id   <= '0;
      bus.timeout    <= 1'b0;
    end else begin
      bus.timeout <= 1'b0;
      case (state)
        IDLE: begin
          state          <= arb_state;
          bus.proc_gnt   <= arb_proc_gnt;
          bus.cont_gnt   <= arb_cont_gnt;
          bus.owner_id   <= arb_owner;
          bus.owner_cont <= arb_cont;
          bus.busy       <= (arb_state != IDLE);
          idle_cnt       <= '0;
          served         <= '0;
        end

        PROC_RUN: begin
          if (proc_done) begin
            rr_ptr         <= rr_after_owner;
            idle_cnt       <= '0;
            state          <= arb_state;
            bus.proc_gnt   <= arb_proc_gnt;
            bus.cont_gnt   <= arb_cont_gnt;
            bus.owner_id   <= arb_owner;
            bus.owner_cont <= arb_cont;
            bus.busy       <= (arb_state != IDLE);
          end else if (proc_beat) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IDLE_LIMIT) begin
            // Stalled owner: release to IDLE and arbitrate on the next edge.
            rr_ptr         <= rr_after_owner;
            idle_cnt       <= '0;
            state          <= IDLE;
            bus.proc_gnt   <= '0;
            bus.cont_gnt   <= '0;
            bus.owner_id   <= '0;
            bus.owner_cont <= 1'b0;
            bus.busy       <= 1'b0;
            bus.timeout    <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + IW'(1);
          end
        end

        CONT_RUN: begin
          // Staying in the batch accumulates the mask; any exit clears it.
          served         <= (arb_state == CONT_RUN) ? (served | bus.cont_gnt) : '0;
          state          <= arb_state;
          bus.proc_gnt   <= arb_proc_gnt;
          bus.cont_gnt   <= arb_cont_gnt;
          bus.owner_id   <= arb_owner;
          bus.owner_cont <= arb_cont;
          bus.busy       <= (arb_state != IDLE);
          idle_cnt       <= '0;
        end

        default: begin
          state          <= IDLE;
          bus.proc_gnt   <= '0;
          bus.cont_gnt   <= '0;
          bus.owner_id   <= '0;
          bus.owner_cont <= 1'b0;
          bus.busy       <= 1'b0;
          idle_cnt       <= '0;
          served         <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_atomic_update_scheduler.sv
// Directed testbench for atomic_update_scheduler (N_PROC=4, N_CONT=2,
// MAX_IDLE=16). Inputs change 1 time unit after a rising edge; outputs are
// checked at that same point, where the registered values of the edge are
// already settled.
module tb_atomic_update_scheduler;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  atomic_update_scheduler_if #(.N_PROC(4), .N_CONT(2)) bus ();

  atomic_update_scheduler #(.N_PROC(4), .N_CONT(2), .MAX_IDLE(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    bus.proc_req  = '0;
    bus.proc_last = '0;
    bus.cont_req  = '0;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.proc_req  = '0;
    bus.proc_last = '0;
    bus.cont_req  = '0;

    // Reset state
    tick(); tick();
    chk("rst_proc_gnt", 32'(bus.proc_gnt), 32'h0);
    chk("rst_cont_gnt", 32'(bus.cont_gnt), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_owner_id", 32'(bus.owner_id), 32'h0);
    chk("rst_timeout", 32'(bus.timeout), 32'h0);
    rst_n = 1'b1;

    // Async reset mid-sequence
    bus.proc_req = 4'b0010;
    tick();
    chk("a_gnt_p1", 32'(bus.proc_gnt), 32'h2);
    chk("a_owner_1", 32'(bus.owner_id), 32'h1);
    chk("a_busy", 32'(bus.busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("a_async_gnt", 32'(bus.proc_gnt), 32'h0);
    chk("a_async_owner", 32'(bus.owner_id), 32'h0);
    chk("a_async_busy", 32'(bus.busy), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("a_regrant_p1", 32'(bus.proc_gnt), 32'h2);
    do_reset();

    // Atomicity: P1 4-beat sequence with cont and P2 arriving at beat 2
    bus.proc_req = 4'b0010;
    tick();
    chk("b_gnt_p1", 32'(bus.proc_gnt), 32'h2);
    tick();
    bus.cont_req = 2'b01;
    bus.proc_req = 4'b0110;
    chk("b_beat2_hold", 32'(bus.proc_gnt), 32'h2);
    tick();
    chk("b_beat3_hold", 32'(bus.proc_gnt), 32'h2);
    chk("b_beat3_nocont", 32'(bus.cont_gnt), 32'h0);
    tick();
    chk("b_beat4_hold", 32'(bus.proc_gnt), 32'h2);
    bus.proc_last = 4'b0010;
    tick();
    chk("b_cont_gnt", 32'(bus.cont_gnt), 32'h1);
    chk("b_proc_drop", 32'(bus.proc_gnt), 32'h0);
    chk("b_owner_cont", 32'(bus.owner_cont), 32'h1);
    bus.proc_last = 4'b0000;
    bus.proc_req  = 4'b0100;
    tick();
    bus.cont_req = 2'b00;
    chk("b_cont_done", 32'(bus.cont_gnt), 32'h0);
    chk("b_gnt_p2", 32'(bus.proc_gnt), 32'h4);
    chk("b_owner_2", 32'(bus.owner_id), 32'h2);
    chk("b_owner_proc", 32'(bus.owner_cont), 32'h0);
    do_reset();

    // Round robin, 2-beat sequences, all requesting
    bus.proc_req = 4'b1111;
    tick();
    chk("c_gnt_p0", 32'(bus.proc_gnt), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      bus.proc_last = 4'b0000;
      tick();
      chk($sformatf("c_beat1_%0d", i), 32'(bus.proc_gnt), 32'(4'b0001 << ((i - 1) % 4)));
      bus.proc_last = 4'b1111;
      tick();
      chk($sformatf("c_next_%0d", i), 32'(bus.proc_gnt), 32'(4'b0001 << (i % 4)));
      chk($sformatf("c_busy_%0d", i), 32'(bus.busy), 32'h1);
    end
    do_reset();

    // Single cont request with nothing else pending returns to IDLE
    bus.cont_req = 2'b01;
    tick();
    chk("d_single_gnt", 32'(bus.cont_gnt), 32'h1);
    tick();
    bus.cont_req = 2'b00;
    chk("d_single_idle_gnt", 32'(bus.cont_gnt), 32'h0);
    chk("d_single_idle_busy", 32'(bus.busy), 32'h0);

    // Cont batch with P0 pending
    bus.cont_req = 2'b11;
    bus.proc_req = 4'b0001;
    tick();
    chk("d_batch_c0", 32'(bus.cont_gnt), 32'h1);
    chk("d_batch_c0_id", 32'(bus.owner_id), 32'h0);
    tick();
    bus.cont_req = 2'b10;
    chk("d_batch_c1", 32'(bus.cont_gnt), 32'h2);
    chk("d_batch_c1_id", 32'(bus.owner_id), 32'h1);
    tick();
    bus.cont_req = 2'b00;
    chk("d_batch_exit_cont", 32'(bus.cont_gnt), 32'h0);
    chk("d_batch_exit_p0", 32'(bus.proc_gnt), 32'h1);
    do_reset();

    // Watchdog: single-beat P1 moves rr_ptr to 2, P3 then stalls
    bus.proc_req  = 4'b1010;
    bus.proc_last = 4'b0010;
    tick();
    chk("e_single_p1", 32'(bus.proc_gnt), 32'h2);
    tick();
    chk("e_gnt_p3", 32'(bus.proc_gnt), 32'h8);
    bus.proc_last = 4'b0000;
    bus.proc_req  = 4'b1000;
    tick();
    bus.proc_req = 4'b0101;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk($sformatf("e_wait_to_%0d", i), 32'(bus.timeout), 32'h0);
      chk($sformatf("e_wait_gnt_%0d", i), 32'(bus.proc_gnt), 32'h8);
    end
    tick();
    chk("e_timeout", 32'(bus.timeout), 32'h1);
    chk("e_release_gnt", 32'(bus.proc_gnt), 32'h0);
    chk("e_release_busy", 32'(bus.busy), 32'h0);
    tick();
    chk("e_timeout_pulse", 32'(bus.timeout), 32'h0);
    chk("e_gnt_p0", 32'(bus.proc_gnt), 32'h1);
    do_reset();

    // Back-to-back: cont held, P0 single-beat sequences, strict alternation
    bus.cont_req  = 2'b01;
    bus.proc_req  = 4'b0001;
    bus.proc_last = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("f_cont_%0d", i), 32'(bus.cont_gnt), (i % 2 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("f_proc_%0d", i), 32'(bus.proc_gnt), (i % 2 == 0) ? 32'h0 : 32'h1);
    end
    do_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
